// File: rtl/spi_mem_arbiter_pkg.sv
// Shared encodings and constants for the SPI flash read arbiter and the mem_read engine.
package spi_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_FINISH  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam logic [2:0] MAX_READ_BYTES = 3'd4;
  localparam logic [7:0] SPI_CMD_READ   = 8'h03;

  function automatic logic [2:0] clamp_bytes(input logic [2:0] b);
    return (b > MAX_READ_BYTES) ? MAX_READ_BYTES : b;
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; last_grant only advances when the grant is taken.
module rr_arbiter2
  import spi_mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_if,
  input  logic   req_ls,
  input  logic   take,
  output logic   gnt_valid,
  output owner_t gnt_owner
);

  owner_t last_q, last_d;

  always_comb begin
    gnt_valid = req_if | req_ls;
    gnt_owner = OWN_IF;
    if (req_if && req_ls) begin
      gnt_owner = (last_q == OWN_IF) ? OWN_LS : OWN_IF;
    end else if (req_ls) begin
      gnt_owner = OWN_LS;
    end
    last_d = last_q;
    if (take && gnt_valid) begin
      last_d = gnt_owner;
    end
  end

  // Reset to LS so the first tie goes to instruction fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_LS;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI flash read engine between the IF and LS ports, one read at a time,
// with a watchdog that aborts a transfer the engine never completes.
module spi_mem_arbiter
  import spi_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int TO_W           = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [23:0] if_addr,
  input  logic [2:0]  if_bytes,
  output logic [31:0] if_data,
  output logic        if_done,
  output logic        if_err,
  input  logic        ls_req,
  input  logic [23:0] ls_addr,
  input  logic [2:0]  ls_bytes,
  output logic [31:0] ls_data,
  output logic        ls_done,
  output logic        ls_err,
  output logic        mem_start_fetch,
  output logic [23:0] mem_address,
  output logic [2:0]  mem_read_bytes,
  input  logic [31:0] mem_target_data,
  input  logic        mem_fetch_done,
  output logic        busy,
  output state_t      state_dbg
);

  // Requester handshake: req rises with addr/bytes stable and stays high until a one-cycle
  // done or err pulse; dropping req early during ISSUE aborts silently (no pulse).
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [23:0]       addr_q, addr_d;
  logic [2:0]        bytes_q, bytes_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       ls_data_q, ls_data_d;

  logic              gnt_valid;
  owner_t            gnt_owner;
  logic              take;
  logic [2:0]        gnt_bytes;
  logic              owner_req;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_if    (if_req),
    .req_ls    (ls_req),
    .take      (take),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  assign gnt_bytes = clamp_bytes((gnt_owner == OWN_LS) ? ls_bytes : if_bytes);
  assign owner_req = (owner_q == OWN_LS) ? ls_req : if_req;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    bytes_d   = bytes_q;
    wd_d      = wd_q;
    err_d     = err_q;
    if_data_d = if_data_q;
    ls_data_d = ls_data_q;
    take      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          take    = 1'b1;
          owner_d = gnt_owner;
          addr_d  = (gnt_owner == OWN_LS) ? ls_addr : if_addr;
          bytes_d = gnt_bytes;
          wd_d    = '0;
          err_d   = 1'b0;
          // A zero-length read completes with zero data and never touches the flash.
          if (gnt_bytes == 3'd0) begin
            state_d = ST_FINISH;
            if (gnt_owner == OWN_LS) ls_data_d = '0;
            else                     if_data_d = '0;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        wd_d = wd_q + TO_W'(1);
        if (mem_fetch_done) begin
          state_d = ST_FINISH;
          if (owner_q == OWN_LS) ls_data_d = mem_target_data;
          else                   if_data_d = mem_target_data;
        end else if (!owner_req) begin
          state_d = ST_RECOVER;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_RECOVER;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      addr_q    <= '0;
      bytes_q   <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      if_data_q <= '0;
      ls_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      bytes_q   <= bytes_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
      if_data_q <= if_data_d;
      ls_data_q <= ls_data_d;
    end
  end

  // start_fetch is decoded from the state register only, so FINISH and RECOVER give
  // mem_read two low cycles to re-arm.
  assign mem_start_fetch = (state_q == ST_ISSUE);
  assign mem_address     = addr_q;
  assign mem_read_bytes  = bytes_q;
  assign if_data         = if_data_q;
  assign ls_data         = ls_data_q;
  assign if_done         = (state_q == ST_FINISH) && (owner_q == OWN_IF) && !err_q;
  assign if_err          = (state_q == ST_FINISH) && (owner_q == OWN_IF) && err_q;
  assign ls_done         = (state_q == ST_FINISH) && (owner_q == OWN_LS) && !err_q;
  assign ls_err          = (state_q == ST_FINISH) && (owner_q == OWN_LS) && err_q;
  assign busy            = (state_q != ST_IDLE);
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: table of single reads plus hand-written corner sequences.
module tb_spi_mem_arbiter;
  import spi_mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req;
  logic [23:0] if_addr, ls_addr;
  logic [2:0]  if_bytes, ls_bytes;
  logic [31:0] if_data, ls_data;
  logic        if_done, if_err, ls_done, ls_err;
  logic        mem_start_fetch;
  logic [23:0] mem_address;
  logic [2:0]  mem_read_bytes;
  logic [31:0] mem_target_data;
  logic        mem_fetch_done;
  logic        busy;
  state_t      state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  spi_mem_arbiter #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_bytes(if_bytes),
    .if_data(if_data), .if_done(if_done), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_bytes(ls_bytes),
    .ls_data(ls_data), .ls_done(ls_done), .ls_err(ls_err),
    .mem_start_fetch(mem_start_fetch), .mem_address(mem_address),
    .mem_read_bytes(mem_read_bytes), .mem_target_data(mem_target_data),
    .mem_fetch_done(mem_fetch_done), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic owner;
    logic err;
    int   cyc;
  } ev_t;

  ev_t         ev_q[$];
  int          start_cyc_q[$];
  logic [23:0] start_addr_q[$];
  logic [2:0]  start_bytes_q[$];
  logic [31:0] exp_q[$];
  logic        busy_at[64];
  logic        start_at[64];

  int          cyc = 0;
  int          base = 0;
  int          start_cnt = 0;
  int          lat = 1;
  logic        respond = 1'b0;
  logic        start_prev = 1'b0;
  logic [31:0] rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ev_field(input int i, input int f);
    if (i >= ev_q.size()) return 32'hFFFF_FFFF;
    case (f)
      0:       return {31'b0, ev_q[i].owner};
      1:       return {31'b0, ev_q[i].err};
      default: return 32'(ev_q[i].cyc);
    endcase
  endfunction

  function automatic logic [31:0] start_field(input int i, input int f);
    if (i >= start_cyc_q.size()) return 32'hFFFF_FFFF;
    case (f)
      0:       return 32'(start_cyc_q[i]);
      1:       return {8'b0, start_addr_q[i]};
      default: return {29'b0, start_bytes_q[i]};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: observe outputs #1 after the edge, run the mem_read model, record events.
  task automatic step();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    k = cyc - base;
    if (k >= 0 && k < 64) begin
      busy_at[k]  = busy;
      start_at[k] = mem_start_fetch;
    end
    if (mem_start_fetch && !start_prev) begin
      start_cyc_q.push_back(k);
      start_addr_q.push_back(mem_address);
      start_bytes_q.push_back(mem_read_bytes);
    end
    start_prev = mem_start_fetch;
    if (mem_start_fetch) start_cnt++;
    else                 start_cnt = 0;
    mem_fetch_done  = respond && mem_start_fetch && (start_cnt == lat);
    mem_target_data = mem_fetch_done ? rdata : 32'h0;
    if (if_done || if_err) begin
      ev_q.push_back('{1'b0, if_err, k});
      if_req = 1'b0;
    end
    if (ls_done || ls_err) begin
      ev_q.push_back('{1'b1, ls_err, k});
      ls_req = 1'b0;
    end
  endtask

  task automatic clear();
    ev_q.delete();
    start_cyc_q.delete();
    start_addr_q.delete();
    start_bytes_q.delete();
    base = cyc;
    for (int i = 0; i < 64; i++) begin
      busy_at[i]  = 1'bx;
      start_at[i] = 1'bx;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " start"},   {31'b0, mem_start_fetch}, 32'h0);
    chk({tag, " addr"},    {8'b0, mem_address},      32'h0);
    chk({tag, " rbytes"},  {29'b0, mem_read_bytes},  32'h0);
    chk({tag, " if_data"}, if_data,                  32'h0);
    chk({tag, " ls_data"}, ls_data,                  32'h0);
    chk({tag, " pulses"},  {28'b0, if_done, if_err, ls_done, ls_err}, 32'h0);
    chk({tag, " busy"},    {31'b0, busy},            32'h0);
    chk({tag, " state"},   {30'b0, state_dbg},       32'h0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        port;
    logic [23:0] addr;
    logic [2:0]  bytes;
    logic [31:0] rdata;
    int          lat;
    logic        spi;
    logic [2:0]  exp_bytes;
    logic [31:0] exp_data;
    int          done_k;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b0, 24'h000100, 3'd4, 32'hDEADBEEF, 3, 1'b1, 3'd4, 32'hDEADBEEF, 4};
    vecs[1] = '{1'b1, 24'h0ABCDE, 3'd2, 32'h00001234, 2, 1'b1, 3'd2, 32'h00001234, 3};
    vecs[2] = '{1'b1, 24'h123456, 3'd0, 32'h77777777, 1, 1'b0, 3'd0, 32'h00000000, 1};
    vecs[3] = '{1'b1, 24'h00FFFF, 3'd7, 32'hCAFEF00D, 1, 1'b1, 3'd4, 32'hCAFEF00D, 2};
    vecs[4] = '{1'b0, 24'hFFFFFF, 3'd1, 32'h000000A5, 5, 1'b1, 3'd1, 32'h000000A5, 6};

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; if_bytes = '0;
    ls_req = 1'b0; ls_addr = '0; ls_bytes = '0;
    mem_target_data = '0; mem_fetch_done = 1'b0;
    step();
    step();
    check_zero("reset");
    rst = 1'b0;
    step();

    // Single reads, one port at a time.
    for (int i = 0; i < 5; i++) begin
      clear();
      lat = vecs[i].lat;
      rdata = vecs[i].rdata;
      respond = 1'b1;
      if (vecs[i].port) begin
        ls_req = 1'b1; ls_addr = vecs[i].addr; ls_bytes = vecs[i].bytes;
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr; if_bytes = vecs[i].bytes;
      end
      repeat (vecs[i].done_k + 3) step();
      chk($sformatf("v%0d done_count", i), ev_q.size(), 32'd1);
      chk($sformatf("v%0d owner", i), ev_field(0, 0), {31'b0, vecs[i].port});
      chk($sformatf("v%0d err", i), ev_field(0, 1), 32'd0);
      chk($sformatf("v%0d done_cycle", i), ev_field(0, 2), 32'(vecs[i].done_k));
      chk($sformatf("v%0d start_count", i), start_cyc_q.size(), {31'b0, vecs[i].spi});
      if (vecs[i].spi) begin
        chk($sformatf("v%0d start_cycle", i), start_field(0, 0), 32'd1);
        chk($sformatf("v%0d mem_address", i), start_field(0, 1), {8'b0, vecs[i].addr});
        chk($sformatf("v%0d mem_read_bytes", i), start_field(0, 2), {29'b0, vecs[i].exp_bytes});
      end
      chk($sformatf("v%0d data", i), vecs[i].port ? ls_data : if_data, vecs[i].exp_data);
      chk($sformatf("v%0d busy_recover", i), {31'b0, busy_at[vecs[i].done_k + 1]}, 32'd1);
      chk($sformatf("v%0d busy_idle", i), {31'b0, busy_at[vecs[i].done_k + 2]}, 32'd0);
    end

    // Watchdog: engine never answers; err 17 cycles after the grant cycle.
    clear();
    respond = 1'b0;
    if_req = 1'b1; if_addr = 24'h000200; if_bytes = 3'd4;
    repeat (20) step();
    chk("to start_last_issue", {31'b0, start_at[16]}, 32'd1);
    chk("to start_dropped", {31'b0, start_at[17]}, 32'd0);
    chk("to event_count", ev_q.size(), 32'd1);
    chk("to owner", ev_field(0, 0), 32'd0);
    chk("to err_flag", ev_field(0, 1), 32'd1);
    chk("to err_cycle", ev_field(0, 2), 32'd17);
    chk("to if_data_kept", if_data, 32'h000000A5);
    chk("to busy_recover", {31'b0, busy_at[18]}, 32'd1);
    chk("to busy_idle", {31'b0, busy_at[19]}, 32'd0);

    // Owner drops req mid-ISSUE; pending LS request is served afterwards.
    clear();
    respond = 1'b0;
    if_req = 1'b1; if_addr = 24'h000300; if_bytes = 3'd3;
    step();
    ls_req = 1'b1; ls_addr = 24'h000400; ls_bytes = 3'd2;
    repeat (4) step();
    if_req = 1'b0;
    respond = 1'b1; lat = 2; rdata = 32'h55AA1234;
    repeat (7) step();
    chk("drop start_before", {31'b0, start_at[5]}, 32'd1);
    chk("drop start_after", {31'b0, start_at[6]}, 32'd0);
    chk("drop event_count", ev_q.size(), 32'd1);
    chk("drop ls_owner", ev_field(0, 0), 32'd1);
    chk("drop ls_err", ev_field(0, 1), 32'd0);
    chk("drop ls_done_cycle", ev_field(0, 2), 32'd10);
    chk("drop start_count", start_cyc_q.size(), 32'd2);
    chk("drop ls_start_cycle", start_field(1, 0), 32'd8);
    chk("drop ls_address", start_field(1, 1), 32'h00000400);
    chk("drop ls_data", ls_data, 32'h55AA1234);
    chk("drop if_data_kept", if_data, 32'h000000A5);

    // Reset in the middle of ISSUE.
    clear();
    respond = 1'b0;
    if_req = 1'b1; if_addr = 24'h000500; if_bytes = 3'd4;
    repeat (3) step();
    chk("rstmid in_issue", {31'b0, mem_start_fetch}, 32'd1);
    rst = 1'b1;
    if_req = 1'b0;
    step();
    check_zero("rstmid");
    rst = 1'b0;
    step();

    // Simultaneous requests twice: grant order IF, LS, IF, LS; then normal completion.
    clear();
    respond = 1'b1; lat = 2; rdata = 32'h3C3CA5A5;
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      if_addr = (r == 0) ? 24'h111111 : 24'h333333;
      ls_addr = (r == 0) ? 24'h222222 : 24'h444444;
      if_bytes = 3'd4; ls_bytes = 3'd4;
      if_req = 1'b1; ls_req = 1'b1;
      exp_q.push_back(32'd0); exp_q.push_back({8'b0, if_addr});
      exp_q.push_back(32'd1); exp_q.push_back({8'b0, ls_addr});
      repeat (11) step();
    end
    chk("rr event_count", ev_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr%0d owner", i), ev_field(i, 0), exp_q.pop_front());
      chk($sformatf("rr%0d address", i), start_field(i, 1), exp_q.pop_front());
      chk($sformatf("rr%0d err", i), ev_field(i, 1), 32'd0);
    end
    chk("rr if_data", if_data, 32'h3C3CA5A5);
    chk("rr ls_data", ls_data, 32'h3C3CA5A5);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
